// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared master indices, lock state encoding and read-return tag type.
package dmem_arb_pkg;
  localparam logic M_CORE = 1'b0;
  localparam logic M_LOAD = 1'b1;
  typedef enum logic {LK_UNLOCKED, LK_LOCKED} lock_state_e;
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;
endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register that carries read ownership tags alongside memory latency.
module rd_tag_pipe import dmem_arb_pkg::*; #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);
  tag_t r_pipe [DEPTH];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter for the data memory port, with a
// bounded lock for master 1 and in-order read-data routing back to the owner.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [31:0]       i_m0_wdata,
  input  logic [3:0]        i_m0_bmask,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [31:0]       i_m1_wdata,
  input  logic [3:0]        i_m1_bmask,
  input  logic              i_m1_lock,
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid,
  output logic [31:0]       o_m0_rdata,
  output logic [31:0]       o_m1_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_lock_active
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  lock_state_e      r_state;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_last_gnt;
  logic [31:0]      r_m0_rdata;
  logic [31:0]      r_m1_rdata;
  logic             w_lock_force;
  logic             w_yield;
  logic             w_g0;
  logic             w_g1;
  logic             w_unlock;
  tag_t             w_tag_in;
  tag_t             w_tag_out;

  assign o_lock_active = (r_state == LK_LOCKED);
  assign w_lock_force  = o_lock_active & i_m1_req & (r_lock_cnt < CNT_MAX);
  assign w_yield       = (r_lock_cnt == CNT_MAX) & i_m0_req;
  // Lock forcing and yield are mutually exclusive (cnt below vs. at MAX_LOCK).
  assign w_g1 = i_rst_n & (w_lock_force | (!w_yield & i_m1_req & (!i_m0_req | r_last_gnt == M_CORE)));
  assign w_g0 = i_rst_n & !w_lock_force & (w_yield | (i_m0_req & (!i_m1_req | r_last_gnt == M_LOAD)));
  assign w_unlock = !i_m1_lock | !i_m1_req | (w_yield & w_g0);

  assign o_m0_gnt    = w_g0;
  assign o_m1_gnt    = w_g1;
  assign o_mem_en    = w_g0 | w_g1;
  assign o_mem_we    = w_g1 ? i_m1_we : (w_g0 & i_m0_we);
  assign o_mem_addr  = w_g1 ? i_m1_addr : i_m0_addr;
  assign o_mem_wdata = w_g1 ? i_m1_wdata : i_m0_wdata;
  assign o_mem_bmask = w_g1 ? i_m1_bmask : i_m0_bmask;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= LK_UNLOCKED;
      r_lock_cnt <= '0;
      r_last_gnt <= M_LOAD;
    end else begin
      if (o_mem_en) r_last_gnt <= w_g1;
      if (r_state == LK_LOCKED) begin
        if (w_unlock) begin
          r_state    <= LK_UNLOCKED;
          r_lock_cnt <= '0;
        end else if (w_g1 && r_lock_cnt != CNT_MAX) begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end else if (w_g1 && i_m1_lock) begin
        r_state    <= LK_LOCKED;
        r_lock_cnt <= CNT_W'(1);
      end
    end
  end

  assign w_tag_in = '{valid: o_mem_en & !o_mem_we, owner: w_g1};

  rd_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  // Read data is passed straight through on the return cycle; the hold
  // registers keep each master's last word between returns.
  assign o_m0_rvalid = i_rst_n & w_tag_out.valid & (w_tag_out.owner == M_CORE);
  assign o_m1_rvalid = i_rst_n & w_tag_out.valid & (w_tag_out.owner == M_LOAD);
  assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : r_m0_rdata;
  assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : r_m1_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (o_m0_rvalid) r_m0_rdata <= i_mem_rdata;
      if (o_m1_rvalid) r_m1_rdata <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiters (MEM_LAT 1..3) driven in lockstep; expected grants and
// read returns are queued by the stimulus and consumed by a negedge monitor per instance.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_bmask, m1_bmask;

  logic [2:0]  m0_gnt, m1_gnt, m0_rv, m1_rv, mem_en, mem_we, lock_act;
  logic [31:0] m0_rd [3];
  logic [31:0] m1_rd [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [15:0] mem_addr [3];
  logic [3:0]  mem_bmask [3];

  typedef struct {int cyc; int g; logic we; logic [15:0] addr; logic lk;} gexp_t;
  typedef struct {int cyc; logic owner; logic [31:0] data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  int    rst_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    logic [31:0] mem [256];
    logic [31:0] dl [g+1];
    bit          mem_init;
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h10] <= 32'hDEADBEEF;
        mem[8'h20] <= 32'hCAFEF00D;
        mem_init <= 1'b1;
      end else if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_bmask[g][b]) mem[mem_addr[g][7:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      dl[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][7:0]] : 32'h0;
      for (int i = 1; i <= g; i++) dl[i] <= dl[i-1];
    end
    assign mem_rdata[g] = dl[g];

    dmem_arbiter #(.ADDR_W(16), .MEM_LAT(g + 1), .MAX_LOCK(8)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_m0_req      (m0_req),
      .i_m0_we       (m0_we),
      .i_m0_addr     (m0_addr),
      .i_m0_wdata    (m0_wdata),
      .i_m0_bmask    (m0_bmask),
      .i_m1_req      (m1_req),
      .i_m1_we       (m1_we),
      .i_m1_addr     (m1_addr),
      .i_m1_wdata    (m1_wdata),
      .i_m1_bmask    (m1_bmask),
      .i_m1_lock     (m1_lock),
      .o_m0_gnt      (m0_gnt[g]),
      .o_m1_gnt      (m1_gnt[g]),
      .o_m0_rvalid   (m0_rv[g]),
      .o_m1_rvalid   (m1_rv[g]),
      .o_m0_rdata    (m0_rd[g]),
      .o_m1_rdata    (m1_rd[g]),
      .o_mem_en      (mem_en[g]),
      .o_mem_we      (mem_we[g]),
      .o_mem_addr    (mem_addr[g]),
      .o_mem_wdata   (mem_wdata[g]),
      .o_mem_bmask   (mem_bmask[g]),
      .i_mem_rdata   (mem_rdata[g]),
      .o_lock_active (lock_act[g])
    );
  end

  int          vec = 0;
  int          bad = 0;
  int          gp [3] = '{0, 0, 0};
  int          rp [3] = '{0, 0, 0};
  logic [31:0] h0 [3] = '{0, 0, 0};
  logic [31:0] h1 [3] = '{0, 0, 0};
  bit          done = 0;
  bit          drained = 0;
  bit          ev0, ev1;
  gexp_t       ge;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lat%0d cyc %0d: got %h expected %h", nm, k + 1, cyc, act, exp);
    end
  endtask

  function automatic bit dropped(input int c, input int l);
    foreach (rst_q[i]) if (rst_q[i] > c && rst_q[i] <= c + l) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (gp[k] < gq.size() && gq[gp[k]].cyc == cyc) begin
        ge = gq[gp[k]];
        gp[k]++;
        chk("m0_gnt", k, 32'(m0_gnt[k]), 32'(ge.g == 1));
        chk("m1_gnt", k, 32'(m1_gnt[k]), 32'(ge.g == 2));
        chk("lock_active", k, 32'(lock_act[k]), 32'(ge.lk));
        chk("mem_en", k, 32'(mem_en[k]), 32'(ge.g != 0));
        chk("mem_we", k, 32'(mem_we[k]), 32'(ge.we));
        if (ge.g != 0) chk("mem_addr", k, 32'(mem_addr[k]), 32'(ge.addr));
        while (rp[k] < rq.size() && dropped(rq[rp[k]].cyc, k + 1)) rp[k]++;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (rp[k] < rq.size() && rq[rp[k]].cyc + k + 1 == cyc) begin
          ev0 = !rq[rp[k]].owner;
          ev1 = rq[rp[k]].owner;
          if (ev0) h0[k] = rq[rp[k]].data;
          else h1[k] = rq[rp[k]].data;
          rp[k]++;
        end
        chk("m0_rvalid", k, 32'(m0_rv[k]), 32'(ev0));
        chk("m1_rvalid", k, 32'(m1_rv[k]), 32'(ev1));
        chk("m0_rdata", k, m0_rd[k], h0[k]);
        chk("m1_rdata", k, m1_rd[k], h1[k]);
        if (!rst_n) begin
          h0[k] = 32'h0;
          h1[k] = 32'h0;
        end
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      for (int k = 0; k < 3; k++) begin
        while (rp[k] < rq.size() && dropped(rq[rp[k]].cyc, k + 1)) rp[k]++;
        chk("reads_drained", k, 32'(rp[k]), 32'(rq.size()));
      end
    end
  end

  task automatic tick(input int eg, input logic elk, input logic [31:0] ed);
    gq.push_back('{cyc, eg, (eg == 1) ? m0_we : (eg == 2) ? m1_we : 1'b0,
                   (eg == 2) ? m1_addr : m0_addr, elk});
    if (eg != 0 && !((eg == 1) ? m0_we : m1_we)) rq.push_back('{cyc, eg == 2, ed});
    if (!rst_n) rst_q.push_back(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_bmask = b;
  endtask

  task automatic set1(input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic lk);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_bmask = b; m1_lock = lk;
  endtask

  task automatic idle(input int n);
    set0(0, 0, 16'h0, 32'h0, 4'h0);
    set1(0, 0, 16'h0, 32'h0, 4'h0, 0);
    repeat (n) tick(0, 0, 32'h0);
  endtask

  task automatic do_reset();
    set0(0, 0, 16'h0, 32'h0, 4'h0);
    set1(0, 0, 16'h0, 32'h0, 4'h0, 0);
    rst_n = 1'b0;
    tick(0, 0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set0(0, 0, 16'h0, 32'h0, 4'h0);
    set1(0, 0, 16'h0, 32'h0, 4'h0, 0);
    @(posedge clk);
    #1;
    tick(0, 0, 32'h0);
    rst_n = 1'b1;
    // single master read
    set0(1, 0, 16'h0010, 32'h0, 4'hF);
    tick(1, 0, 32'hDEADBEEF);
    idle(4);
    // contention right after reset alternates starting with m0
    do_reset();
    set0(1, 0, 16'h0010, 32'h0, 4'hF);
    set1(1, 0, 16'h0020, 32'h0, 4'hF, 0);
    tick(1, 0, 32'hDEADBEEF);
    tick(2, 0, 32'hCAFEF00D);
    tick(1, 0, 32'hDEADBEEF);
    tick(2, 0, 32'hCAFEF00D);
    idle(4);
    // lock burst: eight m1 grants, one yield to m0, then m1 wins the tie
    do_reset();
    set1(1, 0, 16'h0020, 32'h0, 4'hF, 1);
    tick(2, 0, 32'hCAFEF00D);
    tick(2, 1, 32'hCAFEF00D);
    set0(1, 0, 16'h0010, 32'h0, 4'hF);
    repeat (6) tick(2, 1, 32'hCAFEF00D);
    tick(1, 1, 32'hDEADBEEF);
    tick(2, 0, 32'hCAFEF00D);
    set1(0, 0, 16'h0, 32'h0, 4'h0, 0);
    tick(1, 1, 32'hDEADBEEF);
    idle(4);
    // masked write then read back
    do_reset();
    set1(1, 1, 16'h0004, 32'h12345678, 4'b0011, 0);
    tick(2, 0, 32'h0);
    set1(0, 0, 16'h0, 32'h0, 4'h0, 0);
    set0(1, 0, 16'h0004, 32'h0, 4'hF);
    tick(1, 0, 32'h00005678);
    idle(4);
    // reset with reads in flight
    set0(1, 0, 16'h0010, 32'h0, 4'hF);
    tick(1, 0, 32'hDEADBEEF);
    set0(0, 0, 16'h0, 32'h0, 4'h0);
    set1(1, 0, 16'h0020, 32'h0, 4'hF, 0);
    tick(2, 0, 32'hCAFEF00D);
    do_reset();
    idle(4);
    // lock dropped after three grants
    do_reset();
    set1(1, 0, 16'h0020, 32'h0, 4'hF, 1);
    tick(2, 0, 32'hCAFEF00D);
    tick(2, 1, 32'hCAFEF00D);
    tick(2, 1, 32'hCAFEF00D);
    set1(1, 0, 16'h0020, 32'h0, 4'hF, 0);
    set0(1, 0, 16'h0010, 32'h0, 4'hF);
    tick(2, 1, 32'hCAFEF00D);
    tick(1, 0, 32'hDEADBEEF);
    set0(0, 0, 16'h0, 32'h0, 4'h0);
    tick(2, 0, 32'hCAFEF00D);
    idle(5);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
